// File: rtl/build_block_if.sv
// rtl/build_block_if.sv - byte-stream input and block-output handshake bundle for build_block
interface build_block_if;
  logic [7:0]       byte_in;
  logic             byte_valid_in;
  logic             byte_ready_out;
  logic             flush_in;
  logic [15:0][7:0] block_out;
  logic             block_valid_out;
  logic             block_ready_in;
  logic [15:0]      block_count_out;

  modport master (
    output byte_in, byte_valid_in, flush_in, block_ready_in,
    input  byte_ready_out, block_out, block_valid_out, block_count_out
  );

  modport slave (
    input  byte_in, byte_valid_in, flush_in, block_ready_in,
    output byte_ready_out, block_out, block_valid_out, block_count_out
  );
endinterface

// File: rtl/build_block.sv
// rtl/build_block.sv - packs 16 stream bytes into a held 16x8 block with flush/padding
// Optional macro BUILD_BLOCK_PAD_EN selects PKCS#7 padding and whole pad blocks.
module build_block (
  input logic            clk_in,
  input logic            rst_in,
  build_block_if.slave   bus
);
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  logic [0:0]       state;
  logic [4:0]       count;
  logic [15:0][7:0] buffer;
  logic             flush_pending;
  logic [15:0]      block_count;

  logic       accept;
  logic       complete;
  logic       do_pad;
  logic       set_pending;
  logic       xfer;
  logic [4:0] count_next;
  logic [7:0] pad_val;

  assign bus.byte_ready_out  = (state == FILL) && !flush_pending;
  assign bus.block_valid_out = (state == FULL);
  assign bus.block_out       = buffer;
  assign bus.block_count_out = block_count;

  assign accept     = bus.byte_valid_in && bus.byte_ready_out;
  assign count_next = count + {4'd0, accept};
  assign complete   = accept && (count_next == 5'd16);
  assign xfer       = (state == FULL) && bus.block_ready_in;

  // A flush riding on the 16th byte cannot pad this block, so it is deferred
  // (padding build) or dropped (plain build).
`ifdef BUILD_BLOCK_PAD_EN
  assign pad_val     = 8'd16 - {3'd0, count_next};
  assign do_pad      = (state == FILL) && !complete && (bus.flush_in || flush_pending);
  assign set_pending = complete && bus.flush_in;
`else
  assign pad_val     = 8'd0;
  assign do_pad      = (state == FILL) && !complete && bus.flush_in && (count_next != 5'd0);
  assign set_pending = 1'b0;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= FILL;
      count         <= 5'd0;
      buffer        <= '0;
      flush_pending <= 1'b0;
      block_count   <= 16'd0;
    end else begin
      case (state)
        FILL: begin
          for (int k = 0; k < 16; k++) begin
            if (accept && (5'(k) == count))
              buffer[k] <= bus.byte_in;
            else if (do_pad && (5'(k) >= count_next))
              buffer[k] <= pad_val;
          end
          count         <= count_next;
          flush_pending <= set_pending;
          if (complete || do_pad)
            state <= FULL;
        end
        default: begin
          if (xfer) begin
            buffer      <= '0;
            count       <= 5'd0;
            state       <= FILL;
            block_count <= block_count + 16'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_build_block.sv
// tb/tb_build_block.sv - directed vector bench for build_block
module tb_build_block;
`ifdef BUILD_BLOCK_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif

  typedef struct {
    int         n;
    logic [7:0] base;
    logic [7:0] pad;
  } vec_t;

  logic clk_in = 1'b0;
  logic rst_in;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  vec_t vecs[5];
  logic [127:0] held;

  build_block_if bus();
  build_block dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus.slave));

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk_block(input int n, input logic [7:0] base, input logic [7:0] pad);
    logic [127:0] b;
    for (int k = 0; k < 16; k++)
      b[k*8 +: 8] = (k < n) ? base + 8'(k) : pad;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fl);
    bus.byte_in       = b;
    bus.byte_valid_in = 1'b1;
    bus.flush_in      = fl;
    tick();
    bus.byte_valid_in = 1'b0;
    bus.flush_in      = 1'b0;
  endtask

  task automatic send_run(input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) send_byte(base + 8'(k), 1'b0);
  endtask

  task automatic transfer(input string name);
    bus.block_ready_in = 1'b1;
    tick();
    bus.block_ready_in = 1'b0;
    exp_cnt++;
    check({name, "_valid_clr"}, 128'(bus.block_valid_out), 128'(1'b0));
    check({name, "_count"}, 128'(bus.block_count_out), 128'(exp_cnt));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_valid"}, 128'(bus.block_valid_out), 128'(1'b0));
    check({name, "_block"}, bus.block_out, 128'd0);
    check({name, "_ready"}, 128'(bus.byte_ready_out), 128'(1'b1));
    check({name, "_count"}, 128'(bus.block_count_out), 128'd0);
  endtask

  initial begin
    vecs[0] = '{n: 16, base: 8'h00, pad: 8'h00};
    vecs[1] = '{n: 3,  base: 8'hA0, pad: 8'h0D};
    vecs[2] = '{n: 13, base: 8'h40, pad: 8'h03};
    vecs[3] = '{n: 1,  base: 8'h77, pad: 8'h0F};
    vecs[4] = '{n: 15, base: 8'h10, pad: 8'h01};

    bus.byte_in = 8'h00; bus.byte_valid_in = 1'b0; bus.flush_in = 1'b0; bus.block_ready_in = 1'b0;
    rst_in = 1'b1;
    #12;
    check_reset_outputs("reset");
    rst_in = 1'b0;
    tick();

    // Flush at count 0 with nothing pending
    bus.flush_in = 1'b1;
    tick();
    bus.flush_in = 1'b0;
    check("flush_empty_valid", 128'(bus.block_valid_out), 128'(PAD_ON));
    if (bus.block_valid_out) begin
      check("flush_empty_block", bus.block_out, {16{8'h10}});
      transfer("flush_empty");
    end

    // Table: n bytes, then a separate flush when n < 16
    for (int i = 0; i < 5; i++) begin
      send_run(vecs[i].n - 1, vecs[i].base);
      check($sformatf("v%0d_valid_early", i), 128'(bus.block_valid_out), 128'(1'b0));
      send_byte(vecs[i].base + 8'(vecs[i].n - 1), 1'b0);
      if (vecs[i].n < 16) begin
        check($sformatf("v%0d_valid_noflush", i), 128'(bus.block_valid_out), 128'(1'b0));
        bus.flush_in = 1'b1;
        tick();
        bus.flush_in = 1'b0;
      end
      check($sformatf("v%0d_valid", i), 128'(bus.block_valid_out), 128'(1'b1));
      check($sformatf("v%0d_block", i), bus.block_out,
            mk_block(vecs[i].n, vecs[i].base, PAD_ON ? vecs[i].pad : 8'h00));
      transfer($sformatf("v%0d", i));
      check($sformatf("v%0d_ready_after", i), 128'(bus.byte_ready_out), 128'(1'b1));
    end

    // Flush together with a non-final byte: byte lands, then padding from count+1
    send_run(4, 8'hC0);
    send_byte(8'hC4, 1'b1);
    check("flush_with_byte_block", bus.block_out, mk_block(5, 8'hC0, PAD_ON ? 8'h0B : 8'h00));
    transfer("flush_with_byte");

    // Hold under backpressure with extra bytes offered
    send_run(16, 8'h00);
    held = bus.block_out;
    check("hold_first_block", held, mk_block(16, 8'h00, 8'h00));
    bus.byte_in = 8'hEE; bus.byte_valid_in = 1'b1; bus.flush_in = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("hold_valid_%0d", c), 128'(bus.block_valid_out), 128'(1'b1));
      check($sformatf("hold_block_%0d", c), bus.block_out, held);
      check($sformatf("hold_ready_%0d", c), 128'(bus.byte_ready_out), 128'(1'b0));
    end
    bus.byte_valid_in = 1'b0; bus.flush_in = 1'b0;
    transfer("hold");
    check("hold_cleared", bus.block_out, 128'd0);

    // Flush coinciding with the 16th byte
    send_run(15, 8'h50);
    send_byte(8'h5F, 1'b1);
    check("f16_data_block", bus.block_out, mk_block(16, 8'h50, 8'h00));
    transfer("f16_data");
    check("f16_ready_pending", 128'(bus.byte_ready_out), 128'(!PAD_ON));
    tick();
    check("f16_pad_valid", 128'(bus.block_valid_out), 128'(PAD_ON));
    if (bus.block_valid_out) begin
      check("f16_pad_block", bus.block_out, {16{8'h10}});
      transfer("f16_pad");
    end
    check("f16_ready_final", 128'(bus.byte_ready_out), 128'(1'b1));

    // Async reset mid-block
    send_run(7, 8'h90);
    #2 rst_in = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    #1 rst_in = 1'b0;
    exp_cnt = 0;
    tick();
    send_run(16, 8'h20);
    check("rst_mid_clean", bus.block_out, mk_block(16, 8'h20, 8'h00));

    // Async reset while FULL
    #2 rst_in = 1'b1;
    #1;
    check_reset_outputs("rst_full");
    #1 rst_in = 1'b0;
    tick();
    send_run(16, 8'hE0);
    check("rst_full_clean", bus.block_out, mk_block(16, 8'hE0, 8'h00));
    transfer("rst_full");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
